// File: rtl/pdp8_mem_arbiter.sv
// pdp8_mem_arbiter: round-robin IFU/EXEC arbiter sequencing one PDP-8 memory port with a watchdog.
module pdp8_mem_arbiter #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  ifu_rd_req,
    input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
    output logic [DATA_WIDTH-1:0] ifu_rd_data,
    output logic                  ifu_rd_ack,
    input  logic                  exec_req,
    input  logic                  exec_we,
    input  logic [ADDR_WIDTH-1:0] exec_addr,
    input  logic [DATA_WIDTH-1:0] exec_wdata,
    output logic [DATA_WIDTH-1:0] exec_rd_data,
    output logic                  exec_ack,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rdy,
    output logic                  busy,
    output logic                  err_timeout
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam logic [7:0] TIMEOUT = 8'(TIMEOUT_CYCLES);

    state_t                state, state_nxt;
    logic                  last_exec, last_exec_nxt;
    logic [7:0]            cnt, cnt_nxt, cnt_inc;
    logic                  pick_exec, finish;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  mem_req_nxt, mem_we_nxt, busy_nxt, err_nxt;
    logic [ADDR_WIDTH-1:0] mem_addr_nxt;
    logic [DATA_WIDTH-1:0] mem_wdata_nxt, ifu_rd_data_nxt, exec_rd_data_nxt;
    logic                  ifu_rd_ack_nxt, exec_ack_nxt;

    // last_exec doubles as the current grant while BUSY/DONE
    always_comb begin
        state_nxt        = state;
        last_exec_nxt    = last_exec;
        cnt_nxt          = cnt;
        mem_req_nxt      = mem_req;
        mem_we_nxt       = mem_we;
        mem_addr_nxt     = mem_addr;
        mem_wdata_nxt    = mem_wdata;
        ifu_rd_data_nxt  = ifu_rd_data;
        exec_rd_data_nxt = exec_rd_data;
        ifu_rd_ack_nxt   = 1'b0;
        exec_ack_nxt     = 1'b0;
        err_nxt          = err_timeout;
        rd_val           = '0;
        finish           = 1'b0;
        pick_exec        = exec_req && (!ifu_rd_req || !last_exec);
        cnt_inc          = cnt + 8'd1;
        case (state)
            IDLE: begin
                if (ifu_rd_req || exec_req) begin
                    state_nxt     = BUSY;
                    last_exec_nxt = pick_exec;
                    cnt_nxt       = '0;
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = pick_exec && exec_we;
                    mem_addr_nxt  = pick_exec ? exec_addr : ifu_rd_addr;
                    mem_wdata_nxt = pick_exec ? exec_wdata : '0;
                end
            end
            BUSY: begin
                if (mem_rdy) begin
                    finish = 1'b1;
                    rd_val = mem_rdata;
                end else if (TIMEOUT != 8'd0 && cnt_inc == TIMEOUT) begin
                    finish  = 1'b1;
                    err_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (finish) begin
            state_nxt        = DONE;
            mem_req_nxt      = 1'b0;
            ifu_rd_ack_nxt   = !last_exec;
            exec_ack_nxt     = last_exec;
            ifu_rd_data_nxt  = (!mem_we && !last_exec) ? rd_val : ifu_rd_data;
            exec_rd_data_nxt = (!mem_we && last_exec) ? rd_val : exec_rd_data;
        end
        busy_nxt = state_nxt != IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            last_exec    <= 1'b1;
            cnt          <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            ifu_rd_data  <= '0;
            exec_rd_data <= '0;
            ifu_rd_ack   <= 1'b0;
            exec_ack     <= 1'b0;
            busy         <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            state        <= state_nxt;
            last_exec    <= last_exec_nxt;
            cnt          <= cnt_nxt;
            mem_req      <= mem_req_nxt;
            mem_we       <= mem_we_nxt;
            mem_addr     <= mem_addr_nxt;
            mem_wdata    <= mem_wdata_nxt;
            ifu_rd_data  <= ifu_rd_data_nxt;
            exec_rd_data <= exec_rd_data_nxt;
            ifu_rd_ack   <= ifu_rd_ack_nxt;
            exec_ack     <= exec_ack_nxt;
            busy         <= busy_nxt;
            err_timeout  <= err_nxt;
        end
    end
endmodule

// File: tb/tb_pdp8_mem_arbiter.sv
// tb_pdp8_mem_arbiter: randomized scoreboard bench for pdp8_mem_arbiter with a wait-state memory BFM.
`timescale 1ns/1ps
module tb_pdp8_mem_arbiter;
    localparam int AW = 12;
    localparam int DW = 12;

    logic          clk = 0, reset_n = 0;
    logic          ifu_rd_req = 0, ifu_rd_ack;
    logic [AW-1:0] ifu_rd_addr = '0;
    logic [DW-1:0] ifu_rd_data;
    logic          exec_req = 0, exec_we = 0, exec_ack;
    logic [AW-1:0] exec_addr = '0;
    logic [DW-1:0] exec_wdata = '0, exec_rd_data;
    logic          mem_req, mem_we, mem_rdy = 0, busy, err_timeout;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata = '0;

    always #5 clk = ~clk;

    pdp8_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr), .ifu_rd_data(ifu_rd_data), .ifu_rd_ack(ifu_rd_ack),
        .exec_req(exec_req), .exec_we(exec_we), .exec_addr(exec_addr), .exec_wdata(exec_wdata),
        .exec_rd_data(exec_rd_data), .exec_ack(exec_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rdy(mem_rdy), .busy(busy), .err_timeout(err_timeout)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t          ifu_q[$], exec_q[$];
    int            ack_log[$];
    int            n_chk = 0, n_pass = 0;
    logic [DW-1:0] bfm_mem[1<<AW];
    logic [DW-1:0] ref_mem[1<<AW];
    logic [DW-1:0] exec_last = '0;
    logic          exp_err = 0;
    bit            dead = 0, noise = 0, in_txn = 0;
    int            wait_lo = 0, wait_hi = 0, wcnt = 0, wtarget = 0;
    logic [AW-1:0] cur_addr = '0;
    logic          cur_we = 0;
    logic [DW-1:0] cur_wdata = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    endtask

    task automatic set_wait(input int lo, input int hi);
        wait_lo = lo;
        wait_hi = hi;
        wtarget = $urandom_range(hi, lo);
    endtask

    task automatic flush_model();
        ifu_q.delete();
        exec_q.delete();
        ack_log.delete();
        exec_last = '0;
        exp_err = 0;
    endtask

    // Memory BFM: ready after wtarget wait states, captures and checks the command it serves
    always @(negedge clk) begin
        if (mem_req) begin
            if (!in_txn) begin
                in_txn = 1;
                cur_addr = mem_addr;
                cur_we = mem_we;
                cur_wdata = mem_wdata;
            end else begin
                chk("mem_cmd_stable", 32'({mem_addr, mem_we, mem_wdata}), 32'({cur_addr, cur_we, cur_wdata}));
            end
            mem_rdy = !dead && wcnt == wtarget;
            mem_rdata = mem_rdy ? bfm_mem[mem_addr] : DW'($urandom);
        end else begin
            in_txn = 0;
            mem_rdy = noise ? 1'($urandom) : 1'b0;
            mem_rdata = DW'($urandom);
        end
    end

    always @(posedge clk) begin
        if (mem_req && mem_rdy) begin
            if (mem_we) bfm_mem[mem_addr] = mem_wdata;
            wcnt = 0;
            wtarget = $urandom_range(wait_hi, wait_lo);
        end else begin
            wcnt = mem_req ? wcnt + 1 : 0;
        end
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (reset_n) begin
            if (ifu_rd_ack) begin
                ack_log.push_back(0);
                if (ifu_q.size() == 0) chk("ifu_unexpected_ack", 32'(ifu_rd_ack), 0);
                else begin
                    e = ifu_q.pop_front();
                    chk("ifu_data", 32'(ifu_rd_data), 32'(e.data));
                    chk("ifu_addr", 32'(cur_addr), 32'(e.addr));
                    chk("ifu_we", 32'(cur_we), 0);
                    chk("ifu_err", 32'(err_timeout), 32'(e.err));
                end
            end
            if (exec_ack) begin
                ack_log.push_back(1);
                if (exec_q.size() == 0) chk("exec_unexpected_ack", 32'(exec_ack), 0);
                else begin
                    e = exec_q.pop_front();
                    chk("exec_data", 32'(exec_rd_data), 32'(e.data));
                    chk("exec_addr", 32'(cur_addr), 32'(e.addr));
                    chk("exec_we", 32'(cur_we), 32'(e.we));
                    if (e.we) chk("exec_wdata", 32'(cur_wdata), 32'(e.wdata));
                    chk("exec_err", 32'(err_timeout), 32'(e.err));
                end
            end
            if (ifu_rd_ack || exec_ack) chk("ack_exclusive", 32'(ifu_rd_ack && exec_ack), 0);
            if (mem_req) chk("busy_with_req", 32'(busy), 1);
        end
    end

    task automatic ifu_txn(input logic [AW-1:0] a, input int gap);
        exp_t e;
        int t = 0;
        repeat (gap) @(negedge clk);
        if (dead) exp_err = 1;
        e.addr = a; e.we = 0; e.wdata = '0; e.err = exp_err;
        e.data = dead ? '0 : ref_mem[a];
        ifu_q.push_back(e);
        ifu_rd_addr = a;
        ifu_rd_req = 1;
        do begin @(negedge clk); t++; end while (!ifu_rd_ack && t < 100);
        chk("ifu_ack_in_time", 32'(ifu_rd_ack), 1);
        ifu_rd_req = 0;
    endtask

    task automatic exec_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd, input int gap);
        exp_t e;
        int t = 0;
        repeat (gap) @(negedge clk);
        if (dead) exp_err = 1;
        e.addr = a; e.we = we; e.wdata = wd; e.err = exp_err;
        if (we && !dead) ref_mem[a] = wd;
        e.data = we ? exec_last : (dead ? '0 : ref_mem[a]);
        exec_last = e.data;
        exec_q.push_back(e);
        exec_we = we;
        exec_addr = a;
        exec_wdata = wd;
        exec_req = 1;
        do begin @(negedge clk); t++; end while (!exec_ack && t < 100);
        chk("exec_ack_in_time", 32'(exec_ack), 1);
        exec_req = 0;
    endtask

    // EXEC writes stay in the upper half so IFU fetches never race them
    task automatic exec_rand(input int gap);
        logic we;
        we = 1'($urandom);
        exec_txn(we, we ? {1'b1, 11'($urandom)} : AW'($urandom), DW'($urandom), gap);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time bound");
        $fatal(1);
    end

    initial begin
        int reqc, okc, ackc;
        logic [DW-1:0] v;
        for (int i = 0; i < (1 << AW); i++) begin
            v = DW'($urandom);
            bfm_mem[i] = v;
            ref_mem[i] = v;
        end
        bfm_mem[12'h080] = 12'o7200;
        ref_mem[12'h080] = 12'o7200;
        set_wait(0, 0);
        repeat (2) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_acks", 32'({ifu_rd_ack, exec_ack}), 0);
        chk("rst_data", 32'({ifu_rd_data, exec_rd_data}), 0);
        chk("rst_err", 32'(err_timeout), 0);
        reset_n = 1;
        @(negedge clk);

        // IFU read with zero-wait memory: latency checks
        fork
            ifu_txn(12'h080, 0);
            begin
                @(negedge clk);
                chk("t1_mem_req", 32'(mem_req), 1);
                chk("t1_mem_addr", 32'(mem_addr), 32'h080);
                @(negedge clk);
                chk("t1_ack", 32'(ifu_rd_ack), 1);
                chk("t1_data", 32'(ifu_rd_data), 32'o7200);
                @(negedge clk);
                chk("t1_ack_drop", 32'(ifu_rd_ack), 0);
                chk("t1_busy_drop", 32'(busy), 0);
            end
        join

        // EXEC write with 3 wait states
        set_wait(3, 3);
        reqc = 0; okc = 0; ackc = 0;
        fork
            exec_txn(1, 12'ha80, 12'h123, 0);
            repeat (8) begin
                @(negedge clk);
                if (mem_req) begin
                    reqc++;
                    if (mem_we && mem_addr == 12'ha80 && mem_wdata == 12'h123) okc++;
                end
                if (exec_ack) ackc++;
            end
        join
        chk("t2_req_cycles", 32'(reqc), 4);
        chk("t2_cmd_cycles", 32'(okc), 4);
        chk("t2_ack_count", 32'(ackc), 1);
        chk("t2_rd_data_kept", 32'(exec_rd_data), 0);

        // IFU address change while BUSY is ignored
        fork
            ifu_txn(12'h010, 0);
            begin
                repeat (2) @(negedge clk);
                ifu_rd_addr = 12'h020;
                repeat (3) begin
                    @(negedge clk);
                    if (mem_req) chk("t6_addr_frozen", 32'(mem_addr), 32'h010);
                end
            end
        join

        // Alternation after reset: IFU first
        reset_n = 0;
        @(negedge clk);
        reset_n = 1;
        flush_model();
        set_wait(0, 2);
        fork
            repeat (3) ifu_txn(AW'($urandom_range(12'h7ff, 0)), 0);
            repeat (3) exec_rand(0);
        join
        @(negedge clk);
        chk("t3_ack_total", 32'(ack_log.size()), 6);
        for (int i = 0; i < ack_log.size(); i++) chk("t3_grant_order", 32'(ack_log[i]), 32'(i % 2));

        // Randomized concurrent traffic with mem_rdy noise outside transactions
        noise = 1;
        set_wait(0, 5);
        fork
            repeat (40) ifu_txn(AW'($urandom_range(12'h7ff, 0)), $urandom_range(3, 0));
            repeat (40) exec_rand($urandom_range(3, 0));
        join
        noise = 0;
        @(negedge clk);

        // Watchdog: dead memory
        dead = 1;
        reqc = 0;
        fork
            exec_txn(0, 12'h555, '0, 0);
            repeat (25) begin
                @(negedge clk);
                if (mem_req) reqc++;
            end
        join
        dead = 0;
        chk("t4_req_cycles", 32'(reqc), 16);
        set_wait(0, 3);
        ifu_txn(12'h321, 0);
        exec_rand(1);
        chk("t4_err_sticky", 32'(err_timeout), 1);

        // Reset in the middle of a pending IFU read
        dead = 1;
        ifu_rd_addr = 12'h100;
        ifu_rd_req = 1;
        repeat (3) @(negedge clk);
        chk("t5_pre_req", 32'(mem_req), 1);
        chk("t5_pre_busy", 32'(busy), 1);
        #2 reset_n = 0;
        #1;
        chk("t5_req_async", 32'(mem_req), 0);
        chk("t5_busy_async", 32'(busy), 0);
        chk("t5_ack_async", 32'(ifu_rd_ack), 0);
        chk("t5_err_cleared", 32'(err_timeout), 0);
        ifu_rd_req = 0;
        dead = 0;
        flush_model();
        @(negedge clk);
        reset_n = 1;
        ackc = 0;
        repeat (5) begin
            @(negedge clk);
            if (ifu_rd_ack || exec_ack) ackc++;
        end
        chk("t5_no_ack", 32'(ackc), 0);
        set_wait(1, 1);
        ifu_txn(12'h100, 0);
        @(negedge clk);
        chk("t5_queues_empty", 32'(ifu_q.size() + exec_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
